// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester-side and memory-side bus bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        rq_ce_i;
  logic [N_REQ-1:0]        rq_we_i;
  logic [N_REQ*ADDR_W-1:0] rq_addr_i;
  logic [N_REQ*4-1:0]      rq_width_i;
  logic [N_REQ*DATA_W-1:0] rq_data_i;
  logic [DATA_W-1:0]       rq_data_o;
  logic                    mem_ce_o;
  logic                    mem_we_o;
  logic [ADDR_W-1:0]       mem_addr_o;
  logic [3:0]              mem_width_o;
  logic [DATA_W-1:0]       mem_data_o;
  logic [DATA_W-1:0]       mem_data_i;
  logic                    busy_o;
  logic [OWN_W-1:0]        owner_o;
  logic                    overrun_o;

  // Arbiter side
  modport slave (
    input  req_i, rq_ce_i, rq_we_i, rq_addr_i, rq_width_i, rq_data_i, mem_data_i,
    output gnt_o, rq_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o,
           mem_data_o, busy_o, owner_o, overrun_o
  );

  // Requesters plus memory, as seen from outside the arbiter
  modport master (
    output req_i, rq_ce_i, rq_we_i, rq_addr_i, rq_width_i, rq_data_i, mem_data_i,
    input  gnt_o, rq_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o,
           mem_data_o, busy_o, owner_o, overrun_o
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin burst arbiter sharing one memory port between
//               N_REQ requesters, with a one-cycle gap between owners and a
//               hold-limit overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int OWN_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW     = OWN_W + 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] C_HOLD_PRE = HOLD_W'(MAX_HOLD - 1);
  localparam logic [OWN_W-1:0]  C_LAST     = OWN_W'(N_REQ - 1);

  logic [1:0]        state_q,    state_d;
  logic [N_REQ-1:0]  gnt_q,      gnt_d;
  logic [OWN_W-1:0]  owner_q,    owner_d;
  logic [OWN_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              overrun_q,  overrun_d;

  logic              granted;
  logic              any_req;
  logic              owner_req;
  logic              others_req;
  logic [OWN_W-1:0]  pick;
  logic              found;
  logic [CW-1:0]     cand;

  logic              sel_ce;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_width;
  logic [DATA_W-1:0] sel_data;

  assign granted    = (state_q == S_GRANT);
  assign any_req    = |bus.req_i;
  // gnt_q is one-hot on the owner while granted, so it doubles as the owner mask
  assign owner_req  = |(bus.req_i & gnt_q);
  assign others_req = |(bus.req_i & ~gnt_q);

  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!found && bus.req_i[cand[OWN_W-1:0]]) begin
        pick  = cand[OWN_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ce    = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_width = '0;
    sel_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_q == OWN_W'(k)) begin
        sel_ce    = bus.rq_ce_i[k];
        sel_we    = bus.rq_we_i[k];
        sel_addr  = bus.rq_addr_i[k*ADDR_W +: ADDR_W];
        sel_width = bus.rq_width_i[k*4 +: 4];
        sel_data  = bus.rq_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    overrun_d  = 1'b0;
    case (state_q)
      S_GRANT: begin
        if (!owner_req) begin
          state_d  = S_GAP;
          gnt_d    = '0;
          rr_ptr_d = (owner_q == C_LAST) ? '0 : owner_q + OWN_W'(1);
        end else begin
          if (hold_cnt_q != C_HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
          // Only the crossing into MAX_HOLD can fire, so one pulse per grant
          overrun_d = (hold_cnt_q == C_HOLD_PRE) && others_req;
        end
      end
      default: begin
        gnt_d = '0;
        if (any_req) begin
          state_d     = S_GRANT;
          gnt_d[pick] = 1'b1;
          owner_d     = pick;
          hold_cnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.owner_o     = owner_q;
  assign bus.busy_o      = granted;
  assign bus.overrun_o   = overrun_q;
  assign bus.mem_ce_o    = granted & sel_ce;
  assign bus.mem_we_o    = granted & sel_we;
  assign bus.mem_addr_o  = granted ? sel_addr  : '0;
  assign bus.mem_width_o = granted ? sel_width : '0;
  assign bus.mem_data_o  = granted ? sel_data  : '0;
  assign bus.rq_data_o   = bus.mem_data_i;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter against a burst-level
//               reference model, with directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0]         t_req, t_ce, t_we;
  logic [N-1:0][AW-1:0] t_addr;
  logic [N-1:0][3:0]    t_width;
  logic [N-1:0][DW-1:0] t_data;
  logic [DW-1:0]        t_rdata;

  assign bus.req_i      = t_req;
  assign bus.rq_ce_i    = t_ce;
  assign bus.rq_we_i    = t_we;
  assign bus.rq_addr_i  = t_addr;
  assign bus.rq_width_i = t_width;
  assign bus.rq_data_i  = t_data;
  assign bus.mem_data_i = t_rdata;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: who holds the port, who held it last, where the next search starts
  int m_owner, m_last, m_rr, m_hold;
  bit m_ovr;

  int starts[$];
  int cnt [N];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input int start, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_rr = 0; m_hold = 0; m_ovr = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] others;
    int c;
    m_ovr = 1'b0;
    if (m_owner >= 0) begin
      if (!t_req[m_owner]) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        others = t_req;
        others[m_owner] = 1'b0;
        if (m_hold == MH - 1 && others != '0) m_ovr = 1'b1;
        if (m_hold < MH) m_hold++;
      end
    end else begin
      c = first_from(m_rr, t_req);
      if (c >= 0) begin
        m_owner = c; m_last = c; m_hold = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_gnt;
    logic [69:0]  exp_mem, got_mem;
    exp_gnt = '0;
    exp_mem = '0;
    if (m_owner >= 0) begin
      exp_gnt[m_owner] = 1'b1;
      exp_mem = {t_ce[m_owner], t_we[m_owner], t_width[m_owner], t_addr[m_owner], t_data[m_owner]};
    end
    got_mem = {bus.mem_ce_o, bus.mem_we_o, bus.mem_width_o, bus.mem_addr_o, bus.mem_data_o};
    check_eq("gnt",     bus.gnt_o,     exp_gnt);
    check_eq("owner",   bus.owner_o,   m_last);
    check_eq("busy",    bus.busy_o,    m_owner >= 0);
    check_eq("overrun", bus.overrun_o, m_ovr);
    check_eq("mem",     got_mem,       exp_mem);
    check_eq("rdata",   bus.rq_data_o, t_rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_inputs();
    t_req = '0; t_ce = '0; t_we = '0; t_addr = '0; t_width = '0; t_data = '0;
    t_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
  endtask

  // Requesters re-raise after each burst and drop after len grant cycles
  task automatic run_bursts(input int cycles, input int len);
    logic [N-1:0] prev;
    prev = '0;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (bus.gnt_o != '0 && prev == '0) starts.push_back(int'(bus.owner_o));
      prev = bus.gnt_o;
      for (int k = 0; k < N; k++) begin
        if (bus.gnt_o[k]) begin
          cnt[k]++;
          t_addr[k] = AW'(32'h100 * (k + 1) + cnt[k]);
          if (cnt[k] == len) begin
            t_req[k] = 1'b0;
            cnt[k]   = 0;
          end
        end else if (!t_req[k]) begin
          t_req[k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_order [4];
    int pulses, pulse_at;
    rst = 1'b0;
    clear_inputs();
    model_reset();

    // Single requester burst
    do_reset();
    check_eq("reset_gnt", bus.gnt_o, '0);
    t_req = 3'b001;
    t_ce  = 3'b001;
    for (int i = 0; i < 5; i++) begin
      t_addr[0] = AW'(30 + i);
      tick();
      if (i == 0) check_eq("t1_first_gnt", bus.gnt_o, 3'b001);
    end
    t_req = '0;
    tick();
    check_eq("t1_release", bus.gnt_o, 3'b000);
    tick();

    // Full contention, four-cycle bursts
    do_reset();
    t_req = 3'b111;
    t_ce  = 3'b111;
    starts.delete();
    run_bursts(22, 4);
    exp_order = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_order", (i < starts.size()) ? starts[i] : 99, exp_order[i]);
    end

    // Priority rotation after owner 1 releases
    do_reset();
    t_req = 3'b010;
    tick(); tick();
    t_req = 3'b001;
    tick(); tick();
    check_eq("t3_to0", bus.owner_o, 0);
    do_reset();
    t_req = 3'b010;
    tick(); tick();
    t_req = 3'b101;
    tick();
    check_eq("t3_gap", bus.gnt_o, 3'b000);
    tick();
    check_eq("t3_to2", bus.gnt_o, 3'b100);

    // Non-owner bus activity must not leak
    do_reset();
    t_req = 3'b001;
    t_ce  = 3'b011;
    t_we  = 3'b010;
    t_addr[0] = 32'h10;
    t_addr[1] = 32'h80;
    tick(); tick();
    check_eq("t4_we",   bus.mem_we_o,   1'b0);
    check_eq("t4_addr", bus.mem_addr_o, 32'h10);

    // Hold-limit overrun
    do_reset();
    t_req = 3'b001;
    tick();
    t_req = 3'b011;
    pulses = 0;
    pulse_at = -1;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (bus.overrun_o) begin
        pulses++;
        pulse_at = i;
      end
    end
    check_eq("t5_pulses",   pulses,    1);
    check_eq("t5_pulse_at", pulse_at,  MH);
    check_eq("t5_kept",     bus.gnt_o, 3'b001);

    // Asynchronous reset mid-burst
    do_reset();
    t_req = 3'b001;
    t_ce  = 3'b001;
    tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_gnt",  bus.gnt_o,    3'b000);
    check_eq("t6_ce",   bus.mem_ce_o, 1'b0);
    check_eq("t6_busy", bus.busy_o,   1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    t_req = 3'b010;
    rst = 1'b1;
    tick();
    check_eq("t6_regrant", bus.gnt_o, 3'b010);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 11) == 0) t_req[k] = ~t_req[k];
        t_ce[k]    = 1'($urandom);
        t_we[k]    = 1'($urandom);
        t_addr[k]  = $urandom;
        t_width[k] = 4'($urandom);
        t_data[k]  = $urandom;
      end
      t_rdata = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
